// File: rtl/ram16k_copier_if.sv
// rtl/ram16k_copier_if.sv - RAM16K port bundle between the copy engine and the RAM
//
// Signals:
//   ram_address  word address driven by the initiator
//   ram_in       write data driven by the initiator
//   ram_load     write enable; the RAM stores ram_in on the rising clock edge
//   ram_out      combinational read data returned by the RAM for ram_address
// Modports:
//   master  copy engine side (drives address/in/load, receives out)
//   slave   RAM side
interface ram16k_copier_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) ();
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_in;
    logic              ram_load;
    logic [DATA_W-1:0] ram_out;

    modport master (
        output ram_address,
        output ram_in,
        output ram_load,
        input  ram_out
    );

    modport slave (
        input  ram_address,
        input  ram_in,
        input  ram_load,
        output ram_out
    );
endinterface

// File: rtl/ram16k_copier.sv
// rtl/ram16k_copier.sv - overlap-safe RAM16K block-copy engine, one word per two cycles
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset
//   start  copy request, sampled only while idle
//   src    first source word address
//   dst    first destination word address
//   len    word count; anything above 2^ADDR_W is treated as 2^ADDR_W
//   busy   high while a copy is reading/writing
//   done   one-cycle pulse when a copy (including an empty one) completes
//   ram    RAM16K port (master side)
module ram16k_copier #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    ram16k_copier_if.master   ram
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_next;

    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] data;
    logic              backward;

    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W-1:0] len_low;
    logic [ADDR_W-1:0] offset;
    logic              go_backward;

    // A destination that starts inside the source window ahead of it would be
    // clobbered by a forward copy before it is read, so walk from the top down.
    // The full-length case has len_low == 0, making src+len_low-1 == src-1.
    always_comb begin
        len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
        len_low     = len_clamped[ADDR_W-1:0];
        offset      = dst - src;
        go_backward = (offset != '0) && ({1'b0, offset} < len_clamped);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        busy            = 1'b0;
        done            = 1'b0;
        ram.ram_load    = 1'b0;
        ram.ram_address = '0;
        ram.ram_in      = data;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len_clamped == '0) ? DONE : READ;
                end
            end
            READ: begin
                busy            = 1'b1;
                ram.ram_address = src_ptr;
                state_next      = WRITE;
            end
            WRITE: begin
                busy            = 1'b1;
                ram.ram_address = dst_ptr;
                ram.ram_load    = 1'b1;
                state_next      = (count == CNT_ONE) ? DONE : READ;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            data     <= '0;
            backward <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        backward <= go_backward;
                        count    <= len_clamped;
                        if (go_backward) begin
                            src_ptr <= src + len_low - PTR_ONE;
                            dst_ptr <= dst + len_low - PTR_ONE;
                        end else begin
                            src_ptr <= src;
                            dst_ptr <= dst;
                        end
                    end
                end
                READ: begin
                    data <= ram.ram_out;
                end
                WRITE: begin
                    count <= count - CNT_ONE;
                    if (backward) begin
                        src_ptr <= src_ptr - PTR_ONE;
                        dst_ptr <= dst_ptr - PTR_ONE;
                    end else begin
                        src_ptr <= src_ptr + PTR_ONE;
                        dst_ptr <= dst_ptr + PTR_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram16k_copier.sv
// tb/tb_ram16k_copier.sv - self-checking bench for ram16k_copier
module tb_ram16k_copier;

    localparam int ASZ  = 16384;
    localparam int MASK = ASZ - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [13:0] src = '0;
    logic [13:0] dst = '0;
    logic [14:0] len = '0;
    logic        busy;
    logic        done;

    ram16k_copier_if #(.ADDR_W(14), .DATA_W(16)) ram_bus ();

    ram16k_copier #(.ADDR_W(14), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .src   (src),
        .dst   (dst),
        .len   (len),
        .busy  (busy),
        .done  (done),
        .ram   (ram_bus)
    );

    always #5 clk = ~clk;

    bit [15:0] mem  [ASZ];
    bit [15:0] refm [ASZ];

    logic        pl_we = 1'b0;
    logic [13:0] pl_addr = '0;
    logic [15:0] pl_data = '0;
    int          wr_count = 0;
    int          wr_log [0:20000];

    assign ram_bus.ram_out = mem[ram_bus.ram_address];

    always @(posedge clk) begin
        if (ram_bus.ram_load) begin
            mem[ram_bus.ram_address] <= ram_bus.ram_in;
            if (wr_count <= 20000) wr_log[wr_count] <= int'(ram_bus.ram_address);
            wr_count <= wr_count + 1;
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic poke_mem(input int a, input logic [15:0] v);
        pl_addr = a[13:0];
        pl_data = v;
        pl_we   = 1'b1;
        @(posedge clk);
        #1 pl_we = 1'b0;
        refm[a] = v;
    endtask

    task automatic load_pattern();
        for (int i = 0; i < 8; i++) poke_mem(i, 16'(i * 16'h1000));
    endtask

    // Reference: clamp, choose the direction by the offset rule, then move
    // words one at a time in that order on a plain array.
    task automatic model_copy(input int s, input int d, input int l,
                              output int lc, output int first);
        int  off;
        bit  back;
        int  k;
        lc   = (l > ASZ) ? ASZ : l;
        off  = (d - s) & MASK;
        back = (off != 0) && (off < lc);
        for (int i = 0; i < lc; i++) begin
            k = back ? (lc - 1 - i) : i;
            refm[(d + k) & MASK] = refm[(s + k) & MASK];
        end
        first = (lc == 0) ? -1 : (back ? ((d + lc - 1) & MASK) : d);
    endtask

    task automatic cmp_mem(input string name);
        int nbad = 0;
        for (int a = 0; a < ASZ; a++) if (mem[a] != refm[a]) nbad++;
        chk(name, nbad, 0);
    endtask

    task automatic run_copy(input int s, input int d, input int l,
                            input int exp_edges, input int exp_first,
                            input bit do_poke, input string tag);
        int lc;
        int mfirst;
        int base;
        int edges;
        model_copy(s, d, l, lc, mfirst);
        @(negedge clk);
        base  = wr_count;
        src   = s[13:0];
        dst   = d[13:0];
        len   = l[14:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        src   = 14'($urandom);
        dst   = 14'($urandom);
        len   = 15'($urandom);
        edges = 1;
        @(negedge clk);
        chk({tag, "_busy_after_accept"}, int'(busy), (lc > 0) ? 1 : 0);
        while (!done && edges < 40000) begin
            if (do_poke && edges == 5) begin
                start = 1'b1;
                src   = 14'd58;
                dst   = 14'd63;
                len   = 15'd4;
            end
            @(posedge clk);
            edges++;
            #1 start = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_done_edges"}, edges, exp_edges);
        chk({tag, "_busy_in_done"}, int'(busy), 0);
        @(negedge clk);
        chk({tag, "_done_pulse_width"}, int'(done), 0);
        chk({tag, "_write_count"}, wr_count - base, lc);
        if (lc > 0) chk({tag, "_first_write_addr"}, wr_log[base], exp_first);
        cmp_mem({tag, "_mem"});
    endtask

    typedef struct {
        int s;
        int d;
        int l;
        bit wrap_pre;
        bit poke;
        int exp_edges;
        int exp_first;
        string tag;
    } vec_t;

    vec_t tv [6];

    initial begin
        int s;
        int d;
        int l;
        int lc;
        int f;
        int base;
        int edges;

        tv[0] = '{0,     16,  8, 1'b0, 1'b0, 17, 16,  "fwd"};
        tv[1] = '{0,     3,   8, 1'b0, 1'b0, 17, 10,  "ovl_back"};
        tv[2] = '{3,     0,   5, 1'b0, 1'b0, 11, 0,   "ovl_fwd"};
        tv[3] = '{16382, 100, 3, 1'b1, 1'b0, 7,  100, "wrap"};
        tv[4] = '{5,     200, 0, 1'b0, 1'b0, 1,  -1,  "len0"};
        tv[5] = '{0,     16,  8, 1'b0, 1'b1, 17, 16,  "start_busy"};

        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_load", int'(ram_bus.ram_load), 0);
        chk("reset_addr", int'(ram_bus.ram_address), 0);
        chk("reset_in", int'(ram_bus.ram_in), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            load_pattern();
            for (int a = 16; a < 24; a++) poke_mem(a, 16'hAAAA);
            if (tv[i].wrap_pre) begin
                poke_mem(16382, 16'h1111);
                poke_mem(16383, 16'h2112);
                poke_mem(0, 16'h0035);
            end
            if (tv[i].poke) poke_mem(63, 16'hBEEF);
            run_copy(tv[i].s, tv[i].d, tv[i].l, tv[i].exp_edges,
                     tv[i].exp_first, tv[i].poke, tv[i].tag);
        end

        // Reset landing in the WRITE cycle of word 3 of an 8-word copy.
        load_pattern();
        for (int a = 16; a < 24; a++) poke_mem(a, 16'hAAAA);
        @(negedge clk);
        base  = wr_count;
        src   = 14'd0;
        dst   = 14'd16;
        len   = 15'd8;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        edges = 1;
        while (edges < 8) begin
            @(posedge clk);
            edges++;
        end
        @(negedge clk);
        chk("rst_pre_load", int'(ram_bus.ram_load), 1);
        reset = 1'b1;
        #1;
        chk("rst_load", int'(ram_bus.ram_load), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_addr", int'(ram_bus.ram_address), 0);
        for (int i = 0; i < 3; i++) refm[16 + i] = refm[i];
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_write_count", wr_count - base, 3);
        cmp_mem("rst_mem");
        run_copy(0, 16, 8, 17, 16, 1'b0, "after_rst");

        // Randomized copies around a randomly filled window, biased to overlap.
        for (int a = 0; a < 256; a++) poke_mem(a, 16'($urandom));
        for (int n = 0; n < 12; n++) begin
            s = $urandom_range(0, 200);
            d = (s + $urandom_range(0, 20) - 10) & MASK;
            l = $urandom_range(0, 40);
            if (n == 0) s = 16380;
            lc = (l > ASZ) ? ASZ : l;
            f  = (lc == 0) ? -1 :
                 ((((d - s) & MASK) != 0 && ((d - s) & MASK) < lc) ? ((d + lc - 1) & MASK) : d);
            run_copy(s, d, l, 2 * lc + 1, f, 1'b0, $sformatf("rnd%0d", n));
        end

        // Over-length request clamps to the whole ring and walks backward.
        run_copy(0, 1, 20000, 2 * ASZ + 1, 0, 1'b0, "clamp");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
